spi_slave_tx_fifo: RTL and testbench

Parametrised SPI slave transmitter; next generation of the single-word mode-0 slave TX. Supports all four SPI modes, MSB- or LSB-first, configurable word width, and a TX FIFO so the AXI side can queue words ahead of the master. SCK and CS are oversampled in the `clk` domain, so there are no multi-edge `always` blocks. Sits between the AXI register file (FIFO writes) and the SPI pins (`so`).

---
 rtl/spi_slave_tx_fifo.sv | 210 +++++++++++++++++++++
 tb/tb_spi_slave_tx_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_tx_fifo.sv
// SPI slave transmitter with a TX FIFO, all four SPI modes and selectable bit order.
// SCK and CS are oversampled in the clk domain and edge-detected; there is a single clock.
module spi_slave_tx_fifo #(
  parameter int unsigned DATA_LEN    = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_en,
  input  logic                          cpol,
  input  logic                          cpha,
  input  logic                          lsb_first,
  input  logic                          wr_en,
  input  logic [DATA_LEN-1:0]           din,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  input  logic                          cs,
  input  logic                          sck,
  output logic                          so,
  output logic                          busy,
  output logic                          qvld,
  output logic                          underrun,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(DATA_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sck_s;
  logic                   cs_s;
  logic                   sck_d;
  logic                   lead;
  logic                   trail;

  logic [DATA_LEN-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [LW-1:0]          level_nxt;
  logic                   push;
  logic                   pop;

  state_t                 state, state_nxt;
  logic [DATA_LEN-1:0]    shreg, shreg_nxt;
  logic [CW-1:0]          bit_cnt, bit_cnt_nxt;
  logic                   so_nxt;
  logic                   qvld_nxt;
  logic                   underrun_nxt;
  logic                   cpol_l, cpha_l, lsb_l;
  logic                   cpol_nxt, cpha_nxt, lsb_nxt;
  logic [DATA_LEN-1:0]    word;

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign lead  = (sck_d == cpol_l) && (sck_s != cpol_l);
  assign trail = (sck_d != cpol_l) && (sck_s == cpol_l);
  assign push  = wr_en && !full;
  assign level_nxt = level + LW'(push) - LW'(pop);

  // Synchronise the SPI pins and keep a delayed SCK copy for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_sync <= '0;
      cs_sync  <= '1;
      sck_d    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
      sck_d    <= sck_s;
    end
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // FIFO pointers, occupancy flags and overflow pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level    <= level_nxt;
      full     <= (level_nxt == LW'(FIFO_DEPTH));
      empty    <= (level_nxt == '0);
      overflow <= wr_en && full;
    end
  end

  // FSM state and registered datapath/outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      so       <= 1'b0;
      qvld     <= 1'b0;
      underrun <= 1'b0;
      busy     <= 1'b0;
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      lsb_l    <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      so       <= so_nxt;
      qvld     <= qvld_nxt;
      underrun <= underrun_nxt;
      busy     <= (state_nxt != S_IDLE);
      cpol_l   <= cpol_nxt;
      cpha_l   <= cpha_nxt;
      lsb_l    <= lsb_nxt;
    end
  end

  // Next-state logic: load a word, shift it out on SCK edges, abort on CS/enable loss.
  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    so_nxt       = so;
    qvld_nxt     = 1'b0;
    underrun_nxt = 1'b0;
    pop          = 1'b0;
    cpol_nxt     = cpol_l;
    cpha_nxt     = cpha_l;
    lsb_nxt      = lsb_l;
    word         = '0;

    unique case (state)
      S_IDLE: begin
        so_nxt      = 1'b0;
        bit_cnt_nxt = '0;
        cpol_nxt    = cpol;
        cpha_nxt    = cpha;
        lsb_nxt     = lsb_first;
        if (!cs_s && tx_en) state_nxt = S_LOAD;
      end

      S_LOAD: begin
        if (cs_s || !tx_en) begin
          state_nxt   = S_IDLE;
          so_nxt      = 1'b0;
          bit_cnt_nxt = '0;
        end else begin
          state_nxt = S_SHIFT;
          if (empty) begin
            underrun_nxt = 1'b1;
          end else begin
            word = mem[rd_ptr];
            pop  = 1'b1;
          end
          if (cpha_l) begin
            shreg_nxt = word;
          end else begin
            so_nxt    = lsb_l ? word[0] : word[DATA_LEN-1];
            shreg_nxt = lsb_l ? (word >> 1) : (word << 1);
          end
        end
      end

      S_SHIFT: begin
        if (cs_s || !tx_en) begin
          state_nxt   = S_IDLE;
          so_nxt      = 1'b0;
          bit_cnt_nxt = '0;
        end else begin
          if (lead && cpha_l) begin
            so_nxt    = lsb_l ? shreg[0] : shreg[DATA_LEN-1];
            shreg_nxt = lsb_l ? (shreg >> 1) : (shreg << 1);
          end
          if (trail) begin
            if (bit_cnt == CW'(DATA_LEN - 1)) begin
              qvld_nxt    = 1'b1;
              bit_cnt_nxt = '0;
              state_nxt   = S_LOAD;
            end else begin
              bit_cnt_nxt = bit_cnt + CW'(1);
              if (!cpha_l) begin
                so_nxt    = lsb_l ? shreg[0] : shreg[DATA_LEN-1];
                shreg_nxt = lsb_l ? (shreg >> 1) : (shreg << 1);
              end
            end
          end
        end
      end

      default: begin
        state_nxt   = S_IDLE;
        so_nxt      = 1'b0;
        bit_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_slave_tx_fifo.sv
// Directed bench for spi_slave_tx_fifo acting as the SPI master and the FIFO writer.
module tb_spi_slave_tx_fifo;

  localparam int unsigned H = 8;  // SCK half period in clk cycles

  logic       clk;
  logic       rst_n;
  logic       tx_en;
  logic       cpol;
  logic       cpha;
  logic       lsb_first;
  logic       wr_en;
  logic [7:0] din;
  logic       full;
  logic       empty;
  logic [2:0] level;
  logic       cs;
  logic       sck;
  logic       so;
  logic       busy;
  logic       qvld;
  logic       underrun;
  logic       overflow;

  int vectors     = 0;
  int miscompares = 0;
  int qvld_cnt    = 0;
  int under_cnt   = 0;
  int snap;
  logic [31:0] rx;

  spi_slave_tx_fifo #(.DATA_LEN(8), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_en     (tx_en),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsb_first (lsb_first),
    .wr_en     (wr_en),
    .din       (din),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .cs        (cs),
    .sck       (sck),
    .so        (so),
    .busy      (busy),
    .qvld      (qvld),
    .underrun  (underrun),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled on the inactive edge.
  always @(negedge clk) begin
    if (qvld === 1'b1)     qvld_cnt  <= qvld_cnt + 1;
    if (underrun === 1'b1) under_cnt <= under_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1;
    din   = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master: n SCK pulses, sampling so on the mode's sample edge, first bit lands highest.
  task automatic pulses(input int n, output logic [31:0] r);
    r = '0;
    for (int i = 0; i < n; i++) begin
      if (!cpha) r = {r[30:0], so};
      sck = ~cpol;
      idle(H);
      if (cpha) r = {r[30:0], so};
      sck = cpol;
      idle(H);
    end
  endtask

  initial begin
    rst_n = 1'b0; tx_en = 1'b1; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    wr_en = 1'b0; din = '0; cs = 1'b1; sck = 1'b0;
    idle(3);
    rst_n = 1'b1;

    // Reset state
    check("rst_so", 32'(so), 32'd0);
    check("rst_qvld", 32'(qvld), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    idle(4);

    // Mode 0, MSB first, 0xA5
    push(8'hA5);
    check("m0_level_pre", 32'(level), 32'd1);
    snap = qvld_cnt;
    cs = 1'b0; idle(8);
    check("m0_busy", 32'(busy), 32'd1);
    pulses(8, rx);
    check("m0_bits", rx, 32'h0000_00A5);
    check("m0_qvld", 32'(qvld_cnt - snap), 32'd1);
    check("m0_level_post", 32'(level), 32'd0);
    cs = 1'b1; idle(8);
    check("m0_busy_after", 32'(busy), 32'd0);

    // Mode 3, LSB first, two back-to-back words
    cpol = 1'b1; cpha = 1'b1; lsb_first = 1'b1; sck = 1'b1;
    idle(8);
    push(8'h3C);
    push(8'h81);
    check("m3_level", 32'(level), 32'd2);
    snap = qvld_cnt;
    cs = 1'b0; idle(8);
    pulses(16, rx);
    check("m3_bits", rx, 32'h0000_3C81);
    check("m3_qvld", 32'(qvld_cnt - snap), 32'd2);
    check("m3_empty", 32'(empty), 32'd1);
    cs = 1'b1; idle(8);

    // FIFO boundaries in mode 0
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; sck = 1'b0;
    idle(8);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    check("fifo_full_3", 32'(full), 32'd0);
    push(8'h44);
    check("fifo_full_4", 32'(full), 32'd1);
    check("fifo_level_4", 32'(level), 32'd4);
    push(8'h55);
    check("fifo_ovf_pulse", 32'(overflow), 32'd1);
    idle(1);
    check("fifo_ovf_clear", 32'(overflow), 32'd0);
    check("fifo_level_ovf", 32'(level), 32'd4);
    snap = qvld_cnt;
    cs = 1'b0; idle(8);
    pulses(32, rx);
    check("fifo_drain", rx, 32'h1122_3344);
    check("fifo_drain_qvld", 32'(qvld_cnt - snap), 32'd4);
    check("fifo_drain_empty", 32'(empty), 32'd1);
    cs = 1'b1; idle(8);

    // Underrun with empty FIFO
    snap = under_cnt;
    cs = 1'b0; idle(8);
    check("ur_pulse", 32'(under_cnt - snap), 32'd1);
    snap = qvld_cnt;
    pulses(8, rx);
    check("ur_bits", rx, 32'd0);
    check("ur_qvld", 32'(qvld_cnt - snap), 32'd1);
    cs = 1'b1; idle(8);

    // CS abort mid-word, then a clean frame
    push(8'hFF);
    push(8'h12);
    snap = qvld_cnt;
    cs = 1'b0; idle(8);
    pulses(3, rx);
    cs = 1'b1; idle(8);
    check("ab_qvld", 32'(qvld_cnt - snap), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_so", 32'(so), 32'd0);
    check("ab_level", 32'(level), 32'd1);
    cs = 1'b0; idle(8);
    pulses(8, rx);
    check("ab_bits2", rx, 32'h0000_0012);
    check("ab_qvld2", 32'(qvld_cnt - snap), 32'd1);
    cs = 1'b1; idle(8);

    // Reset during bit 4
    push(8'hC3);
    push(8'h77);
    cs = 1'b0; idle(8);
    pulses(4, rx);
    check("rm_bits", rx, 32'h0000_000C);
    check("rm_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    idle(1);
    check("rm_so", 32'(so), 32'd0);
    check("rm_qvld", 32'(qvld), 32'd0);
    check("rm_underrun", 32'(underrun), 32'd0);
    check("rm_overflow", 32'(overflow), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_full", 32'(full), 32'd0);
    check("rm_empty", 32'(empty), 32'd1);
    check("rm_level", 32'(level), 32'd0);
    rst_n = 1'b1;
    cs = 1'b1;
    idle(8);
    check("rm_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
